fifo_sync_param: RTL and testbench

- Single-clock, parametrised FIFO for same-clock producer/consumer paths that do not need a vendor FIFO core or clock crossing.
- Generalises the existing 8-bit, fixed-depth FIFO usage with:
  - configurable width and depth;
  - programmable almost-full/almost-empty levels;
  - standard or first-word-fall-through (FWFT) read mode;
  - overflow/underflow error pulses;
  - a reset-busy window.
- Sits between fifo_wr-style producers and fifo_rd-style consumers.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_sdp_ram.sv | 35 +++
 rtl/fifo_sync_param.sv | 173 +++++++++++++++++
 tb/tb_fifo_sync_param.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared mode constants and width helpers for the synchronous FIFO
package fifo_pkg;

  localparam int FIFO_STD          = 0;
  localparam int FIFO_FWFT         = 1;
  localparam int FIFO_RST_BUSY_CYC = 4;

  function automatic int fifo_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra bit so a completely full FIFO (count == DEPTH) is representable.
  function automatic int fifo_count_w(input int depth);
    return fifo_addr_w(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// rtl/fifo_sdp_ram.sv - single-clock simple dual-port RAM with registered read port
module fifo_sdp_ram
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [fifo_addr_w(DEPTH)-1:0]  wr_addr,
  input  logic [DATA_W-1:0]              wr_data,
  input  logic                           rd_en,
  input  logic [fifo_addr_w(DEPTH)-1:0]  rd_addr,
  output logic [DATA_W-1:0]              rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage array is never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - parametrised single-clock FIFO with standard or FWFT read mode
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 256,
  parameter int AF_LEVEL     = DEPTH - 1,
  parameter int AE_LEVEL     = 1,
  parameter int FWFT         = FIFO_STD,
  parameter int RST_BUSY_CYC = FIFO_RST_BUSY_CYC
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_en,
  input  logic [DATA_W-1:0]               wr_data,
  input  logic                            rd_en,
  output logic [DATA_W-1:0]               rd_data,
  output logic                            full,
  output logic                            almost_full,
  output logic                            empty,
  output logic                            almost_empty,
  output logic [fifo_count_w(DEPTH)-1:0]  data_count,
  output logic                            overflow,
  output logic                            underflow,
  output logic                            rst_busy
);

  localparam int AW = fifo_addr_w(DEPTH);
  localparam int CW = fifo_count_w(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  if (DATA_W < 1) begin : g_bad_width
    $error("fifo_sync_param: DATA_W must be >= 1");
  end
  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fifo_sync_param: DEPTH must be a power of two >= 4");
  end
  if (AF_LEVEL > DEPTH) begin : g_bad_af
    $error("fifo_sync_param: AF_LEVEL exceeds DEPTH");
  end
  if (AE_LEVEL >= AF_LEVEL) begin : g_bad_ae
    $error("fifo_sync_param: AE_LEVEL must be below AF_LEVEL");
  end
  if (RST_BUSY_CYC < 2) begin : g_bad_busy
    $error("fifo_sync_param: RST_BUSY_CYC must cover the 2-flop reset synchroniser");
  end
  if ((FWFT != FIFO_STD) && (FWFT != FIFO_FWFT)) begin : g_bad_mode
    $error("fifo_sync_param: FWFT must be FIFO_STD or FIFO_FWFT");
  end

  logic [RST_BUSY_CYC-1:0] busy_sr;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count, count_nxt;
  logic                    full_q, af_q, ae_q, ovf_q, unf_q;
  logic                    wr_acc, rd_acc, ram_re, out_free, empty_int, s1_v;
  logic [DATA_W-1:0]       ram_q, out_data;

  // First two stages double as the reset-release synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_sr <= '0;
    end else begin
      busy_sr <= {busy_sr[RST_BUSY_CYC-2:0], 1'b1};
    end
  end

  assign rst_busy = ~busy_sr[RST_BUSY_CYC-1];
  assign wr_acc   = wr_en & ~full_q & ~rst_busy;
  assign rd_acc   = rd_en & ~empty_int & ~rst_busy;

  always_comb begin
    count_nxt = count;
    if (wr_acc && !rd_acc) begin
      count_nxt = count + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_nxt = count - CW'(1);
    end
  end

  // s1_v marks a word sitting in the RAM read register, waiting to move to out_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      s1_v     <= 1'b0;
      out_data <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (ram_re) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count  <= count_nxt;
      full_q <= (count_nxt == DEPTH_C);
      af_q   <= (count_nxt >= AF_C);
      ae_q   <= (count_nxt <= AE_C);
      ovf_q  <= wr_en & full_q & ~rst_busy;
      unf_q  <= rd_en & empty_int & ~rst_busy;
      s1_v   <= ram_re | (s1_v & ~out_free);
      if (s1_v && out_free) begin
        out_data <= ram_q;
      end
    end
  end

  if (FWFT == FIFO_FWFT) begin : g_fwft
    logic          out_v;
    logic [CW-1:0] ram_cnt;

    // Words still in RAM: total held minus the two prefetch stages.
    assign ram_cnt   = count - CW'(s1_v) - CW'(out_v);
    assign out_free  = ~out_v | rd_acc;
    assign ram_re    = (ram_cnt != '0) & (~s1_v | out_free);
    assign empty_int = ~out_v;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_v <= 1'b0;
      end else if (s1_v && out_free) begin
        out_v <= 1'b1;
      end else if (rd_acc) begin
        out_v <= 1'b0;
      end
    end
  end else begin : g_std
    logic empty_q;

    assign out_free  = 1'b1;
    assign ram_re    = rd_acc;
    assign empty_int = empty_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        empty_q <= 1'b1;
      end else begin
        empty_q <= (count_nxt == '0);
      end
    end
  end

  fifo_sdp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_en   (ram_re),
    .rd_addr (rd_ptr),
    .rd_data (ram_q)
  );

  assign rd_data      = out_data;
  assign full         = full_q | rst_busy;
  assign almost_full  = af_q | rst_busy;
  assign empty        = empty_int;
  assign almost_empty = ae_q;
  assign data_count   = count;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb/tb_fifo_sync_param.sv - directed self-checking bench for fifo_sync_param (standard and FWFT)
module tb_fifo_sync_param;
  import fifo_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       s_wr_en, s_rd_en;
  logic [7:0] s_wr_data, s_rd_data;
  logic       s_full, s_af, s_empty, s_ae, s_ovf, s_unf, s_busy;
  logic [4:0] s_count;

  logic       f_wr_en, f_rd_en;
  logic [7:0] f_wr_data, f_rd_data;
  logic       f_full, f_af, f_empty, f_ae, f_ovf, f_unf, f_busy;
  logic [4:0] f_count;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  fifo_sync_param #(
    .DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(FIFO_STD), .RST_BUSY_CYC(4)
  ) u_std (
    .clk(clk), .rst_n(rst_n), .wr_en(s_wr_en), .wr_data(s_wr_data), .rd_en(s_rd_en),
    .rd_data(s_rd_data), .full(s_full), .almost_full(s_af), .empty(s_empty),
    .almost_empty(s_ae), .data_count(s_count), .overflow(s_ovf), .underflow(s_unf),
    .rst_busy(s_busy)
  );

  fifo_sync_param #(
    .DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(FIFO_FWFT), .RST_BUSY_CYC(4)
  ) u_fwft (
    .clk(clk), .rst_n(rst_n), .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en),
    .rd_data(f_rd_data), .full(f_full), .almost_full(f_af), .empty(f_empty),
    .almost_empty(f_ae), .data_count(f_count), .overflow(f_ovf), .underflow(f_unf),
    .rst_busy(f_busy)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    s_wr_en = 1'b0; s_rd_en = 1'b0; s_wr_data = 8'h00;
    f_wr_en = 1'b0; f_rd_en = 1'b0; f_wr_data = 8'h00;
    repeat (2) tick();

    check("rst_count", s_count, 0);
    check("rst_rd_data", s_rd_data, 8'h00);
    check("rst_ovf", s_ovf, 0);
    check("rst_unf", s_unf, 0);
    check("rst_empty", s_empty, 1);
    check("rst_ae", s_ae, 1);
    check("rst_full", s_full, 1);
    check("rst_af", s_af, 1);
    check("rst_busy", s_busy, 1);
    check("rst_fwft_empty", f_empty, 1);
    check("rst_fwft_rd_data", f_rd_data, 8'h00);

    // Release reset with requests held active through the busy window.
    rst_n = 1'b1;
    s_wr_en = 1'b1; s_wr_data = 8'h55; s_rd_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("busy_e%0d", i), s_busy, (i < 4));
      check($sformatf("busy_full_e%0d", i), s_full, (i < 4));
      check($sformatf("busy_af_e%0d", i), s_af, (i < 4));
      check($sformatf("busy_ovf_e%0d", i), s_ovf, 0);
      check($sformatf("busy_unf_e%0d", i), s_unf, 0);
    end
    s_wr_en = 1'b0; s_rd_en = 1'b0;
    check("post_busy_count", s_count, 0);
    check("post_busy_empty", s_empty, 1);
    check("post_busy_fwft_busy", f_busy, 0);

    // Fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      s_wr_en = 1'b1; s_wr_data = 8'(i);
      tick();
      check($sformatf("fill_count_%0d", i), s_count, i + 1);
      check($sformatf("fill_ae_%0d", i), s_ae, ((i + 1) <= 2));
      check($sformatf("fill_af_%0d", i), s_af, ((i + 1) >= 14));
      check($sformatf("fill_full_%0d", i), s_full, ((i + 1) == 16));
      check($sformatf("fill_ovf_%0d", i), s_ovf, 0);
    end
    s_wr_data = 8'hEE;
    tick();
    check("ovf_pulse", s_ovf, 1);
    check("ovf_count", s_count, 16);
    s_wr_en = 1'b0;
    tick();
    check("ovf_clear", s_ovf, 0);
    check("ovf_count_hold", s_count, 16);

    // Standard drain: data lands one edge after the accepting edge.
    for (int i = 0; i < 16; i++) begin
      s_rd_en = 1'b1;
      tick();
      check($sformatf("drain_count_%0d", i), s_count, 15 - i);
      check($sformatf("drain_empty_%0d", i), s_empty, (i == 15));
      check($sformatf("drain_unf_%0d", i), s_unf, 0);
      if (i > 0) check($sformatf("drain_data_%0d", i), s_rd_data, i - 1);
    end
    tick();
    check("unf_pulse", s_unf, 1);
    check("unf_last_data", s_rd_data, 8'h0F);
    check("unf_count", s_count, 0);
    s_rd_en = 1'b0;
    tick();
    check("unf_clear", s_unf, 0);
    check("unf_data_hold", s_rd_data, 8'h0F);

    // Prefill 8, then concurrent read/write across pointer wrap
    for (int i = 0; i < 8; i++) begin
      s_wr_en = 1'b1; s_wr_data = 8'(8'h20 + i);
      tick();
    end
    check("prefill_count", s_count, 8);
    for (int c = 0; c < 40; c++) begin
      s_wr_en = 1'b1; s_rd_en = 1'b1; s_wr_data = 8'(8'h28 + c);
      tick();
      check($sformatf("wrap_count_%0d", c), s_count, 8);
      check($sformatf("wrap_ovf_%0d", c), s_ovf, 0);
      check($sformatf("wrap_unf_%0d", c), s_unf, 0);
      if (c > 0) check($sformatf("wrap_data_%0d", c), s_rd_data, 8'h20 + c - 1);
    end
    s_rd_en = 1'b0; s_wr_data = 8'h50;
    tick();
    s_wr_en = 1'b0;
    check("wrap_last_data", s_rd_data, 8'h47);
    check("mid_count9", s_count, 9);

    // Mid-operation reset, one cycle low
    rst_n = 1'b0;
    #1;
    check("mid_rst_count", s_count, 0);
    check("mid_rst_rd_data", s_rd_data, 8'h00);
    check("mid_rst_empty", s_empty, 1);
    check("mid_rst_full", s_full, 1);
    check("mid_rst_af", s_af, 1);
    check("mid_rst_ae", s_ae, 1);
    check("mid_rst_busy", s_busy, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) tick();
    check("mid_busy_done", s_busy, 0);
    check("mid_empty", s_empty, 1);
    check("mid_count", s_count, 0);
    s_rd_en = 1'b1;
    tick();
    s_rd_en = 1'b0;
    check("mid_unf", s_unf, 1);
    check("mid_no_stale", s_rd_data, 8'h00);
    tick();
    check("mid_no_stale_hold", s_rd_data, 8'h00);

    // FWFT: write into empty at edge k, visible at k+2
    check("fw_ready", f_busy, 0);
    f_wr_en = 1'b1; f_wr_data = 8'hA5;
    tick();
    f_wr_en = 1'b0;
    check("fw_k_empty", f_empty, 1);
    check("fw_k_count", f_count, 1);
    tick();
    check("fw_k1_empty", f_empty, 1);
    tick();
    check("fw_k2_empty", f_empty, 0);
    check("fw_k2_data", f_rd_data, 8'hA5);
    f_rd_en = 1'b1;
    tick();
    f_rd_en = 1'b0;
    check("fw_rd_empty", f_empty, 1);
    check("fw_rd_count", f_count, 0);
    check("fw_rd_hold", f_rd_data, 8'hA5);

    f_wr_en = 1'b1; f_wr_data = 8'h11;
    tick();
    f_wr_data = 8'h22;
    tick();
    f_wr_en = 1'b0;
    repeat (2) tick();
    check("fw2_head", f_rd_data, 8'h11);
    check("fw2_empty", f_empty, 0);
    check("fw2_count", f_count, 2);
    f_rd_en = 1'b1;
    tick();
    check("fw2_adv_data", f_rd_data, 8'h22);
    check("fw2_adv_empty", f_empty, 0);
    check("fw2_adv_count", f_count, 1);
    tick();
    check("fw2_end_empty", f_empty, 1);
    check("fw2_end_count", f_count, 0);
    check("fw2_end_unf", f_unf, 0);
    tick();
    check("fw_unf", f_unf, 1);
    check("fw_unf_hold", f_rd_data, 8'h22);
    f_rd_en = 1'b0;
    tick();
    check("fw_unf_clear", f_unf, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
